// File: rtl/hex_arbiter_pkg.sv
// Shared types and width helpers for the hex_arbiter block.
// Used by rr_pick and hex_arbiter.
package hex_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LATCH     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // A single requester still needs a one-bit grant index.
  function automatic int gid_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_width(input int busy_timeout);
    return $clog2(busy_timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr,
// otherwise the lowest set request (wrap-around).
module rr_pick
  import hex_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = gid_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   ptr,
  output logic [GID_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns winner/valid and no latch is inferred.
    winner = '0;
    valid  = |req;
    // Wrap region: lowest set index overall, scanned downward so the lowest wins.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) winner = GID_W'(j);
    end
    // Any set index at or above the pointer has priority over the wrap region.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j >= int'(ptr))) winner = GID_W'(j);
    end
  end

endmodule

// File: rtl/hex_arbiter.sv
// Round-robin arbiter sharing one TM1637 hex driver between NUM_REQ requesters.
// Optional word de-duplication is enabled by defining HEX_ARBITER_DEDUP_EN.
module hex_arbiter
  import hex_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 16,
  parameter  int BUSY_TIMEOUT = 16,
  localparam int GID_W        = gid_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      hex_busy,
  output logic                      hex_data_latch,
  output logic [DATA_W-1:0]         hex_data_in,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int CNT_W = cnt_width(BUSY_TIMEOUT);

  state_t            state;
  logic [GID_W-1:0]  rr_ptr;
  logic [GID_W-1:0]  pick;
  logic [GID_W-1:0]  ptr_next;
  logic              pick_valid;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;
  logic              dup_hit;
  logic [DATA_W-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  assign ptr_next    = (pick == GID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
  assign cnt_inc     = wait_cnt + 1'b1;
  assign timeout_hit = (state == WAIT_BUSY) && !hex_busy &&
                       (cnt_inc == CNT_W'(BUSY_TIMEOUT - 1));
  assign busy        = (state != IDLE);

`ifdef HEX_ARBITER_DEDUP_EN
  logic [DATA_W-1:0] last_sent;
  logic              last_valid;

  assign dup_hit = last_valid && (words[pick] == last_sent);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_sent  <= '0;
      last_valid <= 1'b0;
    end else if ((state == LATCH) && hex_data_latch) begin
      last_sent  <= hex_data_in;
      last_valid <= 1'b1;
    end else if (timeout_hit) begin
      last_valid <= 1'b0;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (rst) begin
      state          <= IDLE;
      ack            <= '0;
      hex_data_latch <= 1'b0;
      hex_data_in    <= '0;
      grant_id       <= '0;
      rr_ptr         <= '0;
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
    end else begin
      ack            <= '0;
      hex_data_latch <= 1'b0;
      timeout_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid && !hex_busy) begin
            hex_data_in    <= words[pick];
            grant_id       <= pick;
            rr_ptr         <= ptr_next;
            ack            <= NUM_REQ'(1) << pick;
            hex_data_latch <= !dup_hit;
            state          <= LATCH;
          end
        end
        LATCH: begin
          wait_cnt <= '0;
          // A suppressed duplicate has nothing in flight downstream.
          state    <= hex_data_latch ? WAIT_BUSY : IDLE;
        end
        WAIT_BUSY: begin
          if (hex_busy) begin
            state <= WAIT_DONE;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        WAIT_DONE: begin
          if (!hex_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_arbiter.sv
// Self-checking bench for hex_arbiter: directed table, corner-case sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_hex_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BT = 16;
`ifdef HEX_ARBITER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           hex_busy;
  logic           hex_data_latch;
  logic [W-1:0]   hex_data_in;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  // Downstream hex model: busy for busy_len cycles after each latch pulse.
  int busy_len  = 3;
  int busy_cnt  = 0;
  int rx_count  = 0;
  bit model_clr = 1'b0;

  always #5 clk = ~clk;

  hex_arbiter #(
    .NUM_REQ      (N),
    .DATA_W       (W),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .ack            (ack),
    .hex_busy       (hex_busy),
    .hex_data_latch (hex_data_latch),
    .hex_data_in    (hex_data_in),
    .grant_id       (grant_id),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always @(posedge clk) begin
    if (model_clr) busy_cnt <= 0;
    else if (hex_data_latch) begin
      busy_cnt <= busy_len;
      rx_count <= rx_count + 1;
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign hex_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    req_data[i*W +: W] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; model_clr = 1'b1; req = '0; req_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; model_clr = 1'b0;
  endtask

  // Returns the number of negedges until ack is seen (0 if never).
  task automatic wait_ack(input string name, output int lat);
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        lat = c;
        return;
      end
    end
    fail_bound(name);
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy && !hex_busy) return;
    end
    fail_bound(name);
  endtask

  task automatic test_reset_and_single();
    int lat;
    bit seen_high;
    do_reset();
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_latch", 32'(hex_data_latch), 32'(0));
    check("rst_data", 32'(hex_data_in), 32'(0));
    check("rst_gid", 32'(grant_id), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_terr", 32'(timeout_err), 32'(0));

    busy_len = 100;
    set_word(0, 16'hBEEF);
    req = 4'b0001;
    wait_ack("single_ack_wait", lat);
    check("single_latency", 32'(lat), 32'(1));
    check("single_ack", 32'(ack), 32'(4'b0001));
    check("single_latch", 32'(hex_data_latch), 32'(1));
    check("single_data", 32'(hex_data_in), 32'(16'hBEEF));
    req = '0;
    seen_high = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (hex_busy) seen_high = 1'b1;
      else if (seen_high) break;
    end
    check("single_hex_fell", 32'(hex_busy), 32'(0));
    check("single_busy_on_fall", 32'(busy), 32'(1));
    @(negedge clk);
    check("single_busy_after_fall", 32'(busy), 32'(0));
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           gid;
  } vec_t;

  task automatic test_table();
    vec_t tbl [10];
    int   lat;
    logic [W-1:0] w;
    // Pointer after reset is 0; each grant moves it to winner+1.
    tbl[0] = '{4'b0110, 1};
    tbl[1] = '{4'b0110, 2};
    tbl[2] = '{4'b0011, 0};
    tbl[3] = '{4'b1000, 3};
    tbl[4] = '{4'b1111, 0};
    tbl[5] = '{4'b0001, 0};
    tbl[6] = '{4'b1010, 1};
    tbl[7] = '{4'b1001, 3};
    tbl[8] = '{4'b0100, 2};
    tbl[9] = '{4'b0111, 0};
    do_reset();
    busy_len = 3;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) set_word(i, W'(16'h4000 + k*16 + i));
      req = tbl[k].req;
      wait_ack($sformatf("tbl%0d_wait", k), lat);
      w = W'(16'h4000 + k*16 + tbl[k].gid);
      check($sformatf("tbl%0d_ack", k), 32'(ack), 32'(1) << tbl[k].gid);
      check($sformatf("tbl%0d_gid", k), 32'(grant_id), 32'(tbl[k].gid));
      check($sformatf("tbl%0d_data", k), 32'(hex_data_in), 32'(w));
      check($sformatf("tbl%0d_latch", k), 32'(hex_data_latch), 32'(1));
      req = '0;
      wait_idle($sformatf("tbl%0d_idle", k));
    end
  endtask

  task automatic test_contention();
    int lat;
    int extra;
    bit was_high, fell;
    do_reset();
    busy_len = 20;
    set_word(1, 16'h1111);
    set_word(2, 16'h2222);
    req = 4'b0110;
    wait_ack("cont_wait1", lat);
    check("cont_ack1", 32'(ack), 32'(4'b0010));
    check("cont_data1", 32'(hex_data_in), 32'(16'h1111));
    req[1] = 1'b0;
    was_high = 1'b0; fell = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ack != '0) break;
      if (hex_busy) was_high = 1'b1;
      else if (was_high) fell = 1'b1;
    end
    check("cont_ack2", 32'(ack), 32'(4'b0100));
    check("cont_data2", 32'(hex_data_in), 32'(16'h2222));
    check("cont_after_fall", 32'(fell), 32'(1));
    req = '0;
    wait_idle("cont_idle");
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack != '0) extra++;
    end
    check("cont_no_extra_ack", 32'(extra), 32'(0));
  endtask

  task automatic test_fairness();
    int lat;
    do_reset();
    busy_len = 2;
    for (int i = 0; i < N; i++) set_word(i, W'(16'h3000 + i));
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_ack($sformatf("fair%0d_wait", t), lat);
      check($sformatf("fair%0d_gid", t), 32'(grant_id), 32'(t % N));
      check($sformatf("fair%0d_ack", t), 32'(ack), 32'(1) << (t % N));
    end
    req = '0;
    wait_idle("fair_idle");
  endtask

  task automatic test_timeout();
    int lat;
    int c;
    do_reset();
    busy_len = 0;
    set_word(3, 16'hABCD);
    req = 4'b1000;
    wait_ack("to_wait", lat);
    check("to_ack", 32'(ack), 32'(4'b1000));
    check("to_latch", 32'(hex_data_latch), 32'(1));
    req = '0;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (timeout_err) break;
    end
    check("to_delay", 32'(c), 32'(BT));
    check("to_busy_idle", 32'(busy), 32'(0));
    @(negedge clk);
    check("to_pulse_width", 32'(timeout_err), 32'(0));
    busy_len = 3;
    set_word(0, 16'h0F0F);
    req = 4'b0001;
    wait_ack("to_regrant_wait", lat);
    check("to_regrant_gid", 32'(grant_id), 32'(0));
    check("to_regrant_latch", 32'(hex_data_latch), 32'(1));
    req = '0;
    wait_idle("to_idle");
  endtask

  task automatic test_reset_mid();
    int lat;
    bit prev_hb;
    bit got;
    do_reset();
    busy_len = 50;
    set_word(2, 16'h2D2D);
    req = 4'b0100;
    wait_ack("rm_wait", lat);
    check("rm_gid", 32'(grant_id), 32'(2));
    req = '0;
    repeat (5) @(negedge clk);
    check("rm_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rm_busy", 32'(busy), 32'(0));
    check("rm_ack", 32'(ack), 32'(0));
    check("rm_latch", 32'(hex_data_latch), 32'(0));
    check("rm_gid_rst", 32'(grant_id), 32'(0));
    check("rm_data_rst", 32'(hex_data_in), 32'(0));
    // Downstream is still busy: nothing may be granted until it falls.
    set_word(1, 16'h1A1A);
    set_word(3, 16'h3A3A);
    req = 4'b1010;
    prev_hb = hex_busy;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1'b1;
        break;
      end
      prev_hb = hex_busy;
    end
    if (!got) fail_bound("rm_regrant_wait");
    check("rm_no_grant_while_hex_busy", 32'(prev_hb), 32'(0));
    check("rm_regrant_ack", 32'(ack), 32'(4'b0010));
    check("rm_regrant_gid", 32'(grant_id), 32'(1));
    req = '0;
    wait_idle("rm_idle");
  endtask

  task automatic test_dedup();
    int lat;
    int rx0;
    do_reset();
    busy_len = 3;
    rx0 = rx_count;
    set_word(0, 16'h1234);
    req = 4'b0001;
    wait_ack("dd_wait1", lat);
    check("dd_latch1", 32'(hex_data_latch), 32'(1));
    req = '0;
    wait_idle("dd_idle1");
    req = 4'b0001;
    wait_ack("dd_wait2", lat);
    check("dd_ack2", 32'(ack), 32'(4'b0001));
    check("dd_latch2", 32'(hex_data_latch), 32'(!DEDUP));
    req = '0;
    wait_idle("dd_idle2");
    set_word(0, 16'h5678);
    req = 4'b0001;
    wait_ack("dd_wait3", lat);
    check("dd_latch3", 32'(hex_data_latch), 32'(1));
    check("dd_data3", 32'(hex_data_in), 32'(16'h5678));
    req = '0;
    wait_idle("dd_idle3");
    check("dd_rx_count", 32'(rx_count - rx0), DEDUP ? 32'(2) : 32'(3));
  endtask

  // Transaction-level model: each grant picks the first requester at or after
  // the pointer (mod N) among those requesting at the grant edge.
  task automatic test_random();
    int           pending [N];
    logic [W-1:0] cur [N];
    logic [N-1:0] req_seen;
    int           rr;
    int           w;
    int           rx0;
    int           exp_latches;
    bit           lv;
    logic [W-1:0] ls;
    bit           exp_lat;
    bit           drained;
    do_reset();
    rr = 0; lv = 1'b0; ls = '0; exp_latches = 0; drained = 1'b0;
    rx0 = rx_count;
    req_seen = '0;
    for (int i = 0; i < N; i++) begin
      pending[i] = int'($urandom_range(5, 15));
      cur[i] = '0;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        w = -1;
        for (int j = 0; j < N; j++) begin
          if (w < 0 && req_seen[(rr + j) % N]) w = (rr + j) % N;
        end
        if (w < 0) begin
          check("rnd_unexpected_ack", 32'(ack), 32'(0));
        end else begin
          exp_lat = !(DEDUP && lv && (cur[w] == ls));
          check("rnd_ack", 32'(ack), 32'(1) << w);
          check("rnd_gid", 32'(grant_id), 32'(w));
          check("rnd_data", 32'(hex_data_in), 32'(cur[w]));
          check("rnd_latch", 32'(hex_data_latch), 32'(exp_lat));
          if (exp_lat) begin
            lv = 1'b1;
            ls = cur[w];
            exp_latches++;
          end
          rr = (w + 1) % N;
          pending[w]--;
          req[w] = 1'b0;
          busy_len = int'($urandom_range(1, 4));
        end
      end
      drained = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && pending[i] > 0 && $urandom_range(0, 2) == 0) begin
          cur[i] = W'(16'h0A00 + $urandom_range(0, 3));
          set_word(i, cur[i]);
          req[i] = 1'b1;
        end
        if (pending[i] > 0) drained = 1'b0;
      end
      req_seen = req;
      if (drained) break;
    end
    if (!drained) fail_bound("rnd_drain");
    req = '0;
    wait_idle("rnd_idle");
    check("rnd_rx_count", 32'(rx_count - rx0), 32'(exp_latches));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset_and_single();
    test_table();
    test_contention();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_dedup();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_arbiter.md
Name: hex_arbiter

Overview:
- Shares one `hex` TM1637 display driver between NUM_REQ independent requesters.
- Accepts 16-bit display words on a req/ack handshake and picks one requester per transaction, round-robin.
- Drives the `hex` block's `data_latch`/`data_in` and sequences on its `busy` output, so only one word is in flight at a time.
- Sits between application logic (counters, status sources) and `hex`.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- DATA_W, 16, display word width (4 hex digits).
- BUSY_TIMEOUT, 16, cycles to wait for hex_busy to rise after a latch pulse before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until matching ack.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i uses bits [i*DATA_W +: DATA_W]; stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle pulse: word captured.
- hex_busy  in  1  connects to `hex` busy.
- hex_data_latch  out  1  connects to `hex` data_latch.
- hex_data_in  out  DATA_W  connects to `hex` data_in.
- grant_id  out  GID_W  index of last/current grantee; GID_W = max(1, clog2(NUM_REQ)).
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  one-cycle pulse on busy-timeout abort.

Behaviour:
- Reset (synchronous):
  - state=IDLE; all outputs 0; hex_data_in=0.
  - RR pointer=0, so index 0 has top priority.
  - Timeout counter=0.
- FSM states: IDLE, LATCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Transition when |req && !hex_busy.
  - Winner = first set req bit scanning from the RR pointer upward, wrapping modulo NUM_REQ.
  - On that clock edge: capture req_data[winner] into hex_data_in, set grant_id=winner, set RR pointer=(winner+1) mod NUM_REQ, go to LATCH.
- LATCH (exactly 1 cycle):
  - hex_data_latch=1 and ack[grant_id]=1.
  - Clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - hex_busy=1: go to WAIT_DONE.
  - Otherwise increment the counter. When counter==BUSY_TIMEOUT-1, pulse timeout_err and go to IDLE. The word is dropped; ack was already given.
- WAIT_DONE:
  - Stay until hex_busy=0, then go to IDLE.
  - No timeout here; a TM1637 transfer takes hundreds of µs.
- Latency:
  - From req rising in IDLE (hex idle) to hex_data_latch: 2 cycles.
  - Minimum back-to-back latch spacing: 4 cycles plus hex busy time.
- hex_data_in holds its captured value until the next grant. It is not cleared on IDLE.
- Simultaneous requests: exactly one ack per transaction; the others wait.
- Starvation-free: any held req is granted within NUM_REQ transactions.
- req dropped after capture (LATCH onward): the transaction still completes.
- req dropped while in IDLE: no grant.
- hex_busy already high in IDLE (e.g. after a downstream reset): no grant until it falls.
- rst in any state: returns to IDLE on the next edge. No ack or latch is emitted that cycle; outputs take their reset values.
- NUM_REQ=1: RR pointer is constant 0; grant_id is always 0.

Optional Feature:
- Macro: HEX_ARBITER_DEDUP_EN.
- Defined:
  - Keep last_sent (DATA_W) and last_valid (cleared on reset and on timeout abort).
  - In LATCH, if last_valid && hex_data_in==last_sent: pulse ack, keep hex_data_latch=0, go directly to IDLE.
  - Otherwise latch as normal, then set last_sent=hex_data_in and last_valid=1.
- Undefined: every grant produces a latch pulse, and the registers are absent.

Decomposition:
- Package hex_arbiter_pkg:
  - state enum (IDLE=0, LATCH=1, WAIT_BUSY=2, WAIT_DONE=3), 2-bit encoding.
  - Localparam helpers for GID_W and timeout counter width clog2(BUSY_TIMEOUT+1).
- Sub-module rr_pick:
  - Combinational.
  - Inputs: req vector and pointer.
  - Outputs: winner index and valid.
  - Instantiated once.

Test Plan:
- Single request: req[0]=1, data 16'hBEEF, hex idle → ack[0] and hex_data_latch both high in cycle 2 after req, with hex_data_in=16'hBEEF. A hex_busy model held high for 100 cycles → busy deasserts the cycle after hex_busy falls.
- Contention: req[2] and req[1] rise together (data 16'h2222, 16'h1111) from reset → grant order 1 then 2. Exactly one ack each, and the second latch occurs only after hex_busy falls.
- Fairness: all 4 reqs held continuously for 8 transactions → grant_id sequence 0,1,2,3,0,1,2,3.
- Timeout: hex_busy tied 0, req[3]=1 → latch pulse, then timeout_err pulses BUSY_TIMEOUT cycles later; state returns to IDLE and a new grant proceeds.
- Reset mid-transfer: rst asserted for 1 cycle during WAIT_DONE → busy=0 and ack=0 next cycle; RR pointer back to 0; a subsequent req[1] is granted normally.
- Dedup (HEX_ARBITER_DEDUP_EN): send 16'h1234 twice → second ack with no hex_data_latch. Then send 16'h5678 → latch occurs.
